// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: word width, FSM encodings,
// handshake levels, RV32M divide aluop codes and an operand magnitude helper.
package ex_div_pkg;

    localparam int REG_BUS = 32;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Aluop codes the EX stage decodes into start and the quotient/remainder select.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_REM_OP  = 8'b0001_1100;
    localparam logic [7:0] EXE_REMU_OP = 8'b0001_1101;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS-1:0] magnitude(input logic [REG_BUS-1:0] v,
                                                     input logic               is_signed);
        return (is_signed && v[REG_BUS-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for the EX stage (RV32M DIV/DIVU/REM/REMU).
// One quotient bit per cycle; divide-by-zero short-cuts to the RISC-V defined result.
module ex_div
    import ex_div_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [REG_BUS-1:0] dividend,
    input  logic [REG_BUS-1:0] divisor,
    input  logic               annul,
    output logic [REG_BUS-1:0] quotient,
    output logic [REG_BUS-1:0] remainder,
    output logic               ready,
    output logic               stall_req
);

    div_state_e         state_q;
    logic [5:0]         cnt_q;
    logic [REG_BUS-1:0] part_q, part_d;
    logic [REG_BUS-1:0] dvd_q, dvd_d;
    logic [REG_BUS-1:0] dsr_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [REG_BUS-1:0] quotient_q;
    logic [REG_BUS-1:0] remainder_q;
    logic               ready_q;

    logic [REG_BUS:0]   shifted;
    logic [REG_BUS:0]   trial;

    // One restoring step: dvd_q shifts the dividend out of its top while the
    // quotient bits fill in from the bottom.
    always_comb begin
        shifted = {part_q, dvd_q[REG_BUS-1]};
        trial   = shifted - {1'b0, dsr_q};
        part_d  = shifted[REG_BUS-1:0];
        dvd_d   = {dvd_q[REG_BUS-2:0], 1'b0};
        if (!trial[REG_BUS]) begin
            part_d = trial[REG_BUS-1:0];
            dvd_d  = {dvd_q[REG_BUS-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DIV_FREE;
            cnt_q       <= '0;
            part_q      <= ZERO_WORD;
            dvd_q       <= ZERO_WORD;
            dsr_q       <= ZERO_WORD;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= ZERO_WORD;
            remainder_q <= ZERO_WORD;
            ready_q     <= DIV_RESULT_NOT_READY;
        end else if (annul) begin
            state_q <= DIV_FREE;
            ready_q <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    if (start == DIV_START) begin
                        if (divisor == ZERO_WORD) begin
                            state_q <= DIV_BY_ZERO;
                            dvd_q   <= dividend;
                        end else begin
                            state_q   <= DIV_ON;
                            dvd_q     <= magnitude(dividend, signed_div);
                            dsr_q     <= magnitude(divisor, signed_div);
                            part_q    <= ZERO_WORD;
                            cnt_q     <= '0;
                            neg_quo_q <= signed_div & (dividend[REG_BUS-1] ^ divisor[REG_BUS-1]);
                            neg_rem_q <= signed_div & dividend[REG_BUS-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    quotient_q  <= '1;
                    remainder_q <= dvd_q;
                    ready_q     <= DIV_RESULT_READY;
                    state_q     <= DIV_END;
                end
                DIV_ON: begin
                    part_q <= part_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        // Sign correction also covers 0x80000000 / -1 by plain wrap-around.
                        quotient_q  <= neg_quo_q ? (~dvd_d + 1'b1) : dvd_d;
                        remainder_q <= neg_rem_q ? (~part_d + 1'b1) : part_d;
                        ready_q     <= DIV_RESULT_READY;
                        state_q     <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (start == DIV_STOP) begin
                        ready_q <= DIV_RESULT_NOT_READY;
                        state_q <= DIV_FREE;
                    end
                end
                default: state_q <= DIV_FREE;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ready     = ready_q;
    assign stall_req = start & ~ready_q;

endmodule
